// File: rtl/fetch_queue_pkg.sv
// Shared defaults and the entry type for the instruction prefetch queue.
package fetch_queue_pkg;

    localparam int          FQ_DEPTH_DEFAULT    = 4;
    localparam logic [31:0] FQ_RESET_PC_DEFAULT = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_fq_fifo.sv
// Power-of-two FIFO of fq_entry_t with a combinational head and a flush that
// empties it in one cycle; used both for fetched instructions and pending PCs.
module fq_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  fq_entry_t              push_data,
    input  logic                   pop,
    output fq_entry_t              head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);

    localparam int          PW         = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    fq_entry_t     mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == FULL_COUNT);
    assign do_pop  = pop & ~flush & (count_reg != '0);
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign do_push = push & ~flush & (~full | do_pop);
    assign head    = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues in-order fetches, tags them with their PC,
// and drops stale responses after a redirect. FETCH_QUEUE_BYPASS_EN adds an
// empty-queue bypass from imem_rdata straight to the decode outputs.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = FQ_DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = FQ_RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fpc_reg;
    logic [CW-1:0] outstanding_reg;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_reg;
    logic [CW-1:0] drop_next;

    fq_entry_t     fifo_head;
    fq_entry_t     pcq_head;
    fq_entry_t     pcq_in;
    fq_entry_t     resp_entry;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] pcq_count;
    logic          fifo_full;
    logic          pcq_full;
    logic          grant;
    logic          resp_accept;
    logic          fifo_push;
    logic          fifo_pop;

    // Dropped-stream requests still occupy outstanding, keeping the limit conservative.
    assign imem_req  = ~reset & ~redirect & ~fifo_full & ~pcq_full &
                       (({1'b0, fifo_count} + {1'b0, outstanding_reg}) < DEPTH_W);
    assign imem_addr = fpc_reg;
    assign grant     = imem_req & imem_gnt;

    assign resp_accept = imem_rvalid & ~redirect & (drop_reg == '0) & (pcq_count != '0);
    assign pcq_in      = '{pc: fpc_reg, instr: 32'h0};
    // The PC queue stores a zero instr field, so OR-ing in rdata yields the entry.
    assign resp_entry  = {pcq_head.pc, pcq_head.instr | imem_rdata};

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass    = resp_accept & (fifo_count == '0);
    assign dec_valid = ~reset & ~redirect & ((fifo_count != '0) | bypass);
    assign dec_instr = bypass ? resp_entry.instr : fifo_head.instr;
    assign dec_pc    = bypass ? resp_entry.pc    : fifo_head.pc;
    assign fifo_push = resp_accept & ~(bypass & dec_ready);
`else
    assign dec_valid = ~reset & ~redirect & (fifo_count != '0);
    assign dec_instr = fifo_head.instr;
    assign dec_pc    = fifo_head.pc;
    assign fifo_push = resp_accept;
`endif

    assign fifo_pop = dec_valid & dec_ready & (fifo_count != '0);

    always_comb begin
        outstanding_next = outstanding_reg;
        if (grant && !imem_rvalid) begin
            outstanding_next = outstanding_reg + 1'b1;
        end else if (!grant && imem_rvalid && (outstanding_reg != '0)) begin
            outstanding_next = outstanding_reg - 1'b1;
        end

        // A redirect cycle's own response is already retired in outstanding_next.
        drop_next = drop_reg;
        if (redirect) begin
            drop_next = outstanding_next;
        end else if (imem_rvalid && (drop_reg != '0)) begin
            drop_next = drop_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_reg         <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
        end else begin
            if (redirect) begin
                fpc_reg <= redirect_pc;
            end else if (grant) begin
                fpc_reg <= fpc_reg + 32'd4;
            end
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data (resp_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    // Flushed on redirect: later stale responses are absorbed by drop, not popped here.
    fq_fifo #(
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (grant & ~redirect),
        .push_data (pcq_in),
        .pop       (resp_accept),
        .head      (pcq_head),
        .count     (pcq_count),
        .full      (pcq_full)
    );

endmodule
